register_write_scheduler: RTL and testbench

//  Buffers register writes decoded by the SPI slave and commits them to the voice parameter memory.

---
 rtl/register_pkg.sv | 28 ++
 rtl/register_write_fifo.sv | 54 +++++
 rtl/register_write_scheduler.sv | 140 ++++++++++++++
 tb/tb_register_write_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared types and constants for the register write path between the SPI
// slave and the voice parameter RAM.
package register_pkg;

    localparam int REG_NUM_W   = 16;
    localparam int REG_VALUE_W = 16;

    typedef logic [REG_NUM_W-1:0]   reg_number_t;
    typedef logic [REG_VALUE_W-1:0] reg_value_t;

    typedef struct packed {
        reg_number_t number;
        reg_value_t  value;
    } reg_write_t;

    // Writing this register number clears the sticky overflow state instead
    // of touching the parameter RAM.
    localparam reg_number_t REG_CTRL_CLEAR = 16'hFFFF;

    localparam logic [7:0] OVERFLOW_COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLOT,
        WRITE
    } sched_state_t;

endpackage

// File: rtl/register_write_fifo.sv
// Synchronous FIFO of pending register writes. Pointers carry one extra bit
// so full and empty are told apart without a separate occupancy counter.
module register_write_fifo
    import register_pkg::*;
#(
    parameter int  FIFO_DEPTH = 8,
    parameter type entry_t    = reg_write_t
) (
    input  logic   i_Clock,
    input  logic   i_Reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still taken when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[ADDR_W-1:0]];

    // Advance read/write pointers; wrap-around falls out of the pointer width.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage.
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/register_write_scheduler.sv
// Buffers register writes decoded by the SPI slave and commits them to the
// voice parameter RAM only in slots the voice pipeline leaves free.
// Optional feature macro: REGISTER_WRITE_OVERFLOW_COUNTER_EN adds an 8-bit
// saturating count of dropped commands on o_OverflowCount.
module register_write_scheduler
    import register_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_W      = REG_NUM_W,
    parameter int VALUE_W    = REG_VALUE_W
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               i_RegisterWriteEnable,
    input  logic [NUM_W-1:0]   i_RegisterWriteNumber,
    input  logic [VALUE_W-1:0] i_RegisterWriteValue,
    input  logic               i_PipelineBusyNext,
    output logic               o_ParamWriteEnable,
    output logic [NUM_W-1:0]   o_ParamWriteAddress,
    output logic [VALUE_W-1:0] o_ParamWriteData,
    output logic               o_FifoFull,
    output logic               o_Overflow
`ifdef REGISTER_WRITE_OVERFLOW_COUNTER_EN
    ,
    output logic [7:0]         o_OverflowCount
`endif
);

    typedef struct packed {
        logic [NUM_W-1:0]   number;
        logic [VALUE_W-1:0] value;
    } entry_t;

    localparam logic [NUM_W-1:0] CLEAR_NUMBER = NUM_W'(REG_CTRL_CLEAR);

    sched_state_t state_q;
    sched_state_t state_d;
    logic         enable_last;
    logic         capture;
    logic         drop;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         load_slot;
    logic         clear_cmd;
    entry_t       push_entry;
    entry_t       head;

    // Remember the previous enable level; reset to 1 so a level held across
    // reset is not mistaken for a new command.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) enable_last <= 1'b1;
        else          enable_last <= i_RegisterWriteEnable;
    end

    assign capture    = i_RegisterWriteEnable && !enable_last;
    assign drop       = capture && fifo_full && !fifo_pop;
    assign push_entry = '{number: i_RegisterWriteNumber, value: i_RegisterWriteValue};

    register_write_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (entry_t)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .push      (capture && !drop),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: pop in IDLE, wait for a free RAM slot, strobe once.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        load_slot = 1'b0;
        clear_cmd = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.number == CLEAR_NUMBER) begin
                        clear_cmd = 1'b1;
                    end else begin
                        load_slot = 1'b1;
                        state_d   = WAIT_SLOT;
                    end
                end
            end
            WAIT_SLOT: if (!i_PipelineBusyNext) state_d = WRITE;
            WRITE:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign o_ParamWriteEnable = (state_q == WRITE);
    assign o_FifoFull         = fifo_full;

    // Hold address/data steady from the pop through the write strobe.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            o_ParamWriteAddress <= '0;
            o_ParamWriteData    <= '0;
        end else if (load_slot) begin
            o_ParamWriteAddress <= head.number;
            o_ParamWriteData    <= head.value;
        end
    end

    // Sticky overflow flag; a drop outranks a clear in the same cycle.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset)       o_Overflow <= 1'b0;
        else if (drop)      o_Overflow <= 1'b1;
        else if (clear_cmd) o_Overflow <= 1'b0;
    end

`ifdef REGISTER_WRITE_OVERFLOW_COUNTER_EN
    // Saturating count of dropped commands, restarted by the clear command.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            o_OverflowCount <= '0;
        end else if (drop) begin
            if (clear_cmd)                                o_OverflowCount <= 8'd1;
            else if (o_OverflowCount != OVERFLOW_COUNT_MAX) o_OverflowCount <= o_OverflowCount + 8'd1;
        end else if (clear_cmd) begin
            o_OverflowCount <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_register_write_scheduler.sv
// Directed self-checking bench for register_write_scheduler.
// Honours REGISTER_WRITE_OVERFLOW_COUNTER_EN when checking the drop counter.
module tb_register_write_scheduler;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic        i_RegisterWriteEnable;
    logic [15:0] i_RegisterWriteNumber;
    logic [15:0] i_RegisterWriteValue;
    logic        i_PipelineBusyNext;
    logic        o_ParamWriteEnable;
    logic [15:0] o_ParamWriteAddress;
    logic [15:0] o_ParamWriteData;
    logic        o_FifoFull;
    logic        o_Overflow;
`ifdef REGISTER_WRITE_OVERFLOW_COUNTER_EN
    logic [7:0]  o_OverflowCount;
`endif

    int passed = 0;
    int total  = 0;

    logic [15:0] log_addr [$];
    logic [15:0] log_data [$];

    always #5 i_Clock = ~i_Clock;

    register_write_scheduler #(
        .FIFO_DEPTH (8),
        .NUM_W      (16),
        .VALUE_W    (16)
    ) dut (
        .i_Clock               (i_Clock),
        .i_Reset               (i_Reset),
        .i_RegisterWriteEnable (i_RegisterWriteEnable),
        .i_RegisterWriteNumber (i_RegisterWriteNumber),
        .i_RegisterWriteValue  (i_RegisterWriteValue),
        .i_PipelineBusyNext    (i_PipelineBusyNext),
        .o_ParamWriteEnable    (o_ParamWriteEnable),
        .o_ParamWriteAddress   (o_ParamWriteAddress),
        .o_ParamWriteData      (o_ParamWriteData),
        .o_FifoFull            (o_FifoFull),
        .o_Overflow            (o_Overflow)
`ifdef REGISTER_WRITE_OVERFLOW_COUNTER_EN
        ,
        .o_OverflowCount       (o_OverflowCount)
`endif
    );

    // Record every RAM write strobe, sampled mid-cycle.
    always @(negedge i_Clock) begin
        if (o_ParamWriteEnable === 1'b1) begin
            log_addr.push_back(o_ParamWriteAddress);
            log_data.push_back(o_ParamWriteData);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    // One command: enable high for one cycle, then low for one cycle.
    task automatic pulse(input logic [15:0] num, input logic [15:0] val);
        i_RegisterWriteNumber = num;
        i_RegisterWriteValue  = val;
        i_RegisterWriteEnable = 1'b1;
        tick();
        i_RegisterWriteEnable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_Reset               = 1'b0;
        i_RegisterWriteEnable = 1'b0;
        i_RegisterWriteNumber = '0;
        i_RegisterWriteValue  = '0;
        i_PipelineBusyNext    = 1'b0;
        repeat (3) tick();
        total++; if (o_ParamWriteEnable !== 1'b0) $display("FAIL reset_enable: got %b want 0", o_ParamWriteEnable); else passed++;
        total++; if (o_ParamWriteAddress !== 16'h0) $display("FAIL reset_addr: got %h want 0000", o_ParamWriteAddress); else passed++;
        total++; if (o_ParamWriteData !== 16'h0) $display("FAIL reset_data: got %h want 0000", o_ParamWriteData); else passed++;
        total++; if (o_FifoFull !== 1'b0) $display("FAIL reset_full: got %b want 0", o_FifoFull); else passed++;
        total++; if (o_Overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", o_Overflow); else passed++;
`ifdef REGISTER_WRITE_OVERFLOW_COUNTER_EN
        total++; if (o_OverflowCount !== 8'd0) $display("FAIL reset_count: got %0d want 0", o_OverflowCount); else passed++;
`endif
        i_Reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_write();
        int start = log_addr.size();
        i_RegisterWriteNumber = 16'h0012;
        i_RegisterWriteValue  = 16'hBEEF;
        i_RegisterWriteEnable = 1'b1;
        tick();
        i_RegisterWriteEnable = 1'b0;
        total++; if (o_ParamWriteEnable !== 1'b0) $display("FAIL single_lat1: got %b want 0", o_ParamWriteEnable); else passed++;
        tick();
        total++; if (o_ParamWriteEnable !== 1'b0) $display("FAIL single_lat2: got %b want 0", o_ParamWriteEnable); else passed++;
        tick();
        total++; if (o_ParamWriteEnable !== 1'b1) $display("FAIL single_lat3: got %b want 1", o_ParamWriteEnable); else passed++;
        total++; if (o_ParamWriteAddress !== 16'h0012) $display("FAIL single_addr: got %h want 0012", o_ParamWriteAddress); else passed++;
        total++; if (o_ParamWriteData !== 16'hBEEF) $display("FAIL single_data: got %h want beef", o_ParamWriteData); else passed++;
        tick();
        total++; if (o_ParamWriteEnable !== 1'b0) $display("FAIL single_pulse_end: got %b want 0", o_ParamWriteEnable); else passed++;
        repeat (4) tick();
        total++; if (log_addr.size() - start !== 1) $display("FAIL single_count: got %0d want 1", log_addr.size() - start); else passed++;
    endtask

    task automatic test_held_high();
        int start = log_addr.size();
        i_RegisterWriteNumber = 16'h0056;
        i_RegisterWriteValue  = 16'hCAFE;
        i_RegisterWriteEnable = 1'b1;
        repeat (300) tick();
        i_RegisterWriteEnable = 1'b0;
        repeat (3) tick();
        total++; if (log_addr.size() - start !== 1) $display("FAIL held_count: got %0d want 1", log_addr.size() - start); else passed++;
        if (log_addr.size() > start) begin
            total++; if (log_addr[start] !== 16'h0056) $display("FAIL held_addr: got %h want 0056", log_addr[start]); else passed++;
        end
    endtask

    task automatic test_busy_hold();
        int start = log_addr.size();
        int bad   = 0;
        i_PipelineBusyNext    = 1'b1;
        i_RegisterWriteNumber = 16'h0034;
        i_RegisterWriteValue  = 16'h1234;
        i_RegisterWriteEnable = 1'b1;
        tick();
        i_RegisterWriteEnable = 1'b0;
        i_RegisterWriteNumber = 16'h0000;
        i_RegisterWriteValue  = 16'h0000;
        tick();
        total++; if (o_ParamWriteAddress !== 16'h0034) $display("FAIL busy_addr_loaded: got %h want 0034", o_ParamWriteAddress); else passed++;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_ParamWriteEnable !== 1'b0 || o_ParamWriteAddress !== 16'h0034 || o_ParamWriteData !== 16'h1234) bad++;
        end
        total++; if (bad !== 0) $display("FAIL busy_hold: got %0d bad cycles want 0", bad); else passed++;
        i_PipelineBusyNext = 1'b0;
        total++; if (o_ParamWriteEnable !== 1'b0) $display("FAIL busy_fall_same: got %b want 0", o_ParamWriteEnable); else passed++;
        tick();
        total++; if (o_ParamWriteEnable !== 1'b1) $display("FAIL busy_fall_next: got %b want 1", o_ParamWriteEnable); else passed++;
        total++; if (o_ParamWriteData !== 16'h1234) $display("FAIL busy_data: got %h want 1234", o_ParamWriteData); else passed++;
        repeat (3) tick();
        total++; if (log_addr.size() - start !== 1) $display("FAIL busy_count: got %0d want 1", log_addr.size() - start); else passed++;
    endtask

    task automatic test_overflow();
        int start = log_addr.size();
        i_PipelineBusyNext = 1'b1;
        // Entry 0 parks in WAIT_SLOT, leaving the whole FIFO for entries 1..10.
        pulse(16'h0200, 16'h5A00);
        for (int i = 1; i <= 10; i++) begin
            i_RegisterWriteNumber = 16'h0200 + 16'(i);
            i_RegisterWriteValue  = 16'h5A00 + 16'(i);
            i_RegisterWriteEnable = 1'b1;
            tick();
            total++; if (o_FifoFull !== 1'(i >= 8)) $display("FAIL ovf_full_%0d: got %b want %b", i, o_FifoFull, 1'(i >= 8)); else passed++;
            total++; if (o_Overflow !== 1'(i >= 9)) $display("FAIL ovf_flag_%0d: got %b want %b", i, o_Overflow, 1'(i >= 9)); else passed++;
            i_RegisterWriteEnable = 1'b0;
            tick();
        end
`ifdef REGISTER_WRITE_OVERFLOW_COUNTER_EN
        total++; if (o_OverflowCount !== 8'd2) $display("FAIL ovf_count: got %0d want 2", o_OverflowCount); else passed++;
`endif
        i_PipelineBusyNext = 1'b0;
        for (int c = 0; c < 200 && log_addr.size() < start + 9; c++) tick();
        repeat (6) tick();
        total++; if (log_addr.size() - start !== 9) $display("FAIL ovf_write_count: got %0d want 9", log_addr.size() - start); else passed++;
        for (int k = 0; k < 9; k++) begin
            if (start + k < log_addr.size()) begin
                total++;
                if (log_addr[start+k] !== 16'h0200 + 16'(k) || log_data[start+k] !== 16'h5A00 + 16'(k))
                    $display("FAIL ovf_order_%0d: got %h/%h want %h/%h", k, log_addr[start+k], log_data[start+k],
                             16'h0200 + 16'(k), 16'h5A00 + 16'(k));
                else passed++;
            end
        end
        total++; if (o_Overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", o_Overflow); else passed++;
    endtask

    task automatic test_clear();
        int start = log_addr.size();
        pulse(16'hFFFF, 16'h0001);
        total++; if (o_Overflow !== 1'b0) $display("FAIL clear_flag: got %b want 0", o_Overflow); else passed++;
`ifdef REGISTER_WRITE_OVERFLOW_COUNTER_EN
        total++; if (o_OverflowCount !== 8'd0) $display("FAIL clear_count: got %0d want 0", o_OverflowCount); else passed++;
`endif
        repeat (6) tick();
        total++; if (log_addr.size() - start !== 0) $display("FAIL clear_no_write: got %0d want 0", log_addr.size() - start); else passed++;
    endtask

    task automatic test_reset_in_flight();
        int start;
        int strobes = 0;
        i_PipelineBusyNext = 1'b1;
        pulse(16'h0300, 16'h6000);
        pulse(16'h0301, 16'h6001);
        pulse(16'h0302, 16'h6002);
        i_RegisterWriteNumber = 16'h0303;
        i_RegisterWriteValue  = 16'h6003;
        i_RegisterWriteEnable = 1'b1;
        tick();
        start = log_addr.size();
        // Enable stays high through reset and afterwards.
        i_Reset            = 1'b0;
        i_PipelineBusyNext = 1'b0;
        tick();
        total++; if (o_ParamWriteEnable !== 1'b0) $display("FAIL rif_first_cycle: got %b want 0", o_ParamWriteEnable); else passed++;
        tick();
        i_Reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (o_ParamWriteEnable !== 1'b0) strobes++;
        end
        total++; if (strobes !== 0) $display("FAIL rif_no_strobe: got %0d strobes want 0", strobes); else passed++;
        total++; if (log_addr.size() - start !== 0) $display("FAIL rif_no_write: got %0d want 0", log_addr.size() - start); else passed++;
        total++; if (o_FifoFull !== 1'b0) $display("FAIL rif_full: got %b want 0", o_FifoFull); else passed++;
        // A fresh command must be the very next write, proving nothing was left pending.
        i_RegisterWriteEnable = 1'b0;
        tick();
        pulse(16'h0077, 16'h7777);
        repeat (6) tick();
        total++; if (log_addr.size() - start !== 1) $display("FAIL rif_fresh_count: got %0d want 1", log_addr.size() - start); else passed++;
        if (log_addr.size() > start) begin
            total++; if (log_addr[start] !== 16'h0077) $display("FAIL rif_fresh_addr: got %h want 0077", log_addr[start]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_held_high();
        test_busy_hold();
        test_overflow();
        test_clear();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
